// File: rtl/tt_um_seven_segment_timer.sv
// -----------------------------------------------------------------------------
// tt_um_seven_segment_timer
//
// DIGITS-wide BCD seconds counter with up/down mode, run/clear control and a
// time-multiplexed seven-segment display, sized for the Tiny Tapeout pins.
//
// Optional feature macro: SEG_PWM_EN
//   defined   : an 8-bit free-running PWM counter blanks uo_out whenever
//               pwm_cnt >= ui_in (brightness control). Strobes are never gated.
//   undefined : no PWM counter, ui_in is ignored, uo_out is the plain decode.
//
// Ports
//   clk      in   system clock
//   rst_n    in   asynchronous active-low reset
//   ena      in   design enable; when low every register holds
//   ui_in    in   [7:0] brightness compare value (PWM build only)
//   uio_in   in   [4] run, [5] down, [6] clear (synchronous); others ignored
//   uio_out  out  [3:0] one-hot digit strobe (bit 0 = LSD), [7:4] = 0
//   uio_oe   out  constant 8'h0F
//   uo_out   out  [6:0] segments a..g, [7] half-second indicator
// -----------------------------------------------------------------------------
module tt_um_seven_segment_timer #(
  parameter int MAX_COUNT = 10_000_000,
  parameter int DIGITS    = 4,
  parameter int SCAN_DIV  = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  output logic [7:0] uo_out
);

  localparam int PW = $clog2(MAX_COUNT);
  // A scan divider of 1 still needs a one-bit counter to keep widths legal.
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  localparam logic [PW-1:0] PRESC_LAST = PW'(MAX_COUNT - 1);
  localparam logic [PW-1:0] PRESC_HALF = PW'(MAX_COUNT / 2);
  localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
  localparam logic [1:0]    IDX_LAST   = 2'(DIGITS - 1);

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  // Control decode
  logic w_run;
  logic w_down;
  logic w_clear;
  logic w_tick;
  logic w_unused;

  assign w_run   = uio_in[4];
  assign w_down  = uio_in[5];
  assign w_clear = uio_in[6];

  // State
  logic [PW-1:0]          r_presc;
  logic [DIGITS-1:0][3:0] r_digits;
  logic [SW-1:0]          r_scan_cnt;
  logic [1:0]             r_idx;
  logic [7:0]             r_uo_out;
  logic [7:0]             r_uio_out;

  logic [DIGITS-1:0][3:0] w_digits_next;
  logic [6:0]             w_digit_seg [DIGITS];
  logic [6:0]             w_seg;
  logic [3:0]             w_strobe;
  logic                   w_half;
  logic                   w_gate;

  assign w_tick = ena && w_run && (r_presc == PRESC_LAST);

  // ---------------------------------------------------------------------------
  // Prescaler: holds when run is low; clear wins over everything.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (ena) begin
      if (w_clear) begin
        r_presc <= '0;
      end else if (w_run) begin
        r_presc <= (r_presc == PRESC_LAST) ? '0 : r_presc + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // BCD next value: ripple a carry (up) or borrow (down) from the LSD. A digit
  // only passes the carry on when it wraps, so all-9s -> all-0s and back.
  // ---------------------------------------------------------------------------
  always_comb begin
    logic w_carry;
    w_carry       = 1'b1;
    w_digits_next = r_digits;
    for (int i = 0; i < DIGITS; i++) begin
      if (w_carry) begin
        if (w_down) begin
          if (r_digits[i] == 4'd0) begin
            w_digits_next[i] = 4'd9;
          end else begin
            w_digits_next[i] = r_digits[i] - 4'd1;
            w_carry          = 1'b0;
          end
        end else begin
          if (r_digits[i] >= 4'd9) begin
            w_digits_next[i] = 4'd0;
          end else begin
            w_digits_next[i] = r_digits[i] + 4'd1;
            w_carry          = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digits <= '0;
    end else if (ena) begin
      if (w_clear) begin
        r_digits <= '0;
      end else if (w_tick) begin
        r_digits <= w_digits_next;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Scan: runs whenever enabled, independent of run/clear.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
    end else if (ena) begin
      if (r_scan_cnt == SCAN_LAST) begin
        r_scan_cnt <= '0;
        r_idx      <= (r_idx == IDX_LAST) ? 2'd0 : r_idx + 2'd1;
      end else begin
        r_scan_cnt <= r_scan_cnt + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output stage. Strobe and segment data are both derived from the same
  // r_idx and registered together, so they can never be skewed.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_decode
      assign w_digit_seg[gi] = seg_decode(r_digits[gi]);
    end
  endgenerate

  always_comb begin
    w_seg = 7'h00;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_idx == 2'(i)) begin
        w_seg = w_digit_seg[i];
      end
    end
  end

  assign w_strobe = 4'b0001 << r_idx;
  assign w_half   = w_run && (r_presc < PRESC_HALF);

`ifdef SEG_PWM_EN
  logic [7:0] r_pwm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm <= 8'd0;
    end else if (ena) begin
      r_pwm <= r_pwm + 8'd1;
    end
  end

  // Lit while pwm < ui_in: ui_in=0 blanks, ui_in=255 lights 255/256.
  assign w_gate   = (r_pwm >= ui_in);
  assign w_unused = ^{uio_in[7], uio_in[3:0]};
`else
  assign w_gate   = 1'b0;
  assign w_unused = ^{ui_in, uio_in[7], uio_in[3:0]};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_uo_out  <= 8'h00;
      r_uio_out <= 8'h00;
    end else if (ena) begin
      r_uio_out <= {4'b0000, w_strobe};
      r_uo_out  <= w_gate ? 8'h00 : {w_half, w_seg};
    end
  end

  assign uo_out  = r_uo_out;
  assign uio_out = r_uio_out;
  assign uio_oe  = 8'h0F;

endmodule
